// File: rtl/mem_wb_skid_pkg.sv
// Shared defaults, skid-state encodings and payload packing width for the MEM->WB register.
package mem_wb_skid_pkg;

    localparam int MEMWB_XLEN   = 64;
    localparam int MEMWB_REG_AW = 5;
    localparam int MEMWB_CSR_AW = 12;
    localparam int MEMWB_CNT_W  = 64;

    // State is {main_valid, skid_valid}; 2'b01 cannot be reached.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b10,
        SKID_TWO   = 2'b11
    } skid_state_e;

    function automatic int payload_w(input int xlen, input int reg_aw, input int csr_aw);
        return reg_aw + 1 + xlen + csr_aw + 1 + xlen;
    endfunction

endpackage

// File: rtl/mem_wb_skid_wb_slot.sv
// One writeback payload register with load enable and a synchronous clear of its valid bit.
module mem_wb_skid_wb_slot #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Clear wins over load so a flush always empties the slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_load) begin
                r_data <= i_data;
            end
            if (i_clear) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline register: valid/ready handshake over a main (head) slot and a skid slot,
// with flush, x0 write suppression, gated forwarding copies and a retire counter.
module mem_wb_skid
    import mem_wb_skid_pkg::*;
#(
    parameter int XLEN   = MEMWB_XLEN,
    parameter int REG_AW = MEMWB_REG_AW,
    parameter int CSR_AW = MEMWB_CSR_AW,
    parameter int CNT_W  = MEMWB_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [REG_AW-1:0] i_in_rd_addr,
    input  logic              i_in_wreg,
    input  logic [XLEN-1:0]   i_in_wdata,
    input  logic [CSR_AW-1:0] i_in_csr_waddr,
    input  logic              i_in_csr_wreg,
    input  logic [XLEN-1:0]   i_in_csr_wdata,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [REG_AW-1:0] o_out_rd_addr,
    output logic              o_out_wreg,
    output logic [XLEN-1:0]   o_out_wdata,
    output logic [CSR_AW-1:0] o_out_csr_waddr,
    output logic              o_out_csr_wreg,
    output logic [XLEN-1:0]   o_out_csr_wdata,
    output logic [REG_AW-1:0] o_fwd_rd_addr,
    output logic              o_fwd_wreg,
    output logic [XLEN-1:0]   o_fwd_wdata,
    output logic [CSR_AW-1:0] o_fwd_csr_waddr,
    output logic              o_fwd_csr_wreg,
    output logic [XLEN-1:0]   o_fwd_csr_wdata,
    output logic [CNT_W-1:0]  o_retire_cnt
);

    localparam int PW = payload_w(XLEN, REG_AW, CSR_AW);

    logic [PW-1:0]     w_in_payload;
    logic [PW-1:0]     w_main_d;
    logic [PW-1:0]     w_main_q;
    logic [PW-1:0]     w_skid_q;
    logic              w_main_valid;
    logic              w_skid_valid;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_main_sel_skid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_accept;
    logic              w_consume;
    skid_state_e       w_state;

    logic [REG_AW-1:0] w_h_rd_addr;
    logic              w_h_wreg;
    logic [XLEN-1:0]   w_h_wdata;
    logic [CSR_AW-1:0] w_h_csr_waddr;
    logic              w_h_csr_wreg;
    logic [XLEN-1:0]   w_h_csr_wdata;
    logic              w_gpr_we;
    logic              w_csr_we;

    logic [CNT_W-1:0]  r_retire_cnt;

    assign w_in_payload = {i_in_rd_addr, i_in_wreg, i_in_wdata,
                           i_in_csr_waddr, i_in_csr_wreg, i_in_csr_wdata};

    // in_ready comes straight from the skid valid flop, so it never depends on out_ready.
    assign o_in_ready = ~w_skid_valid;
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_consume  = w_main_valid & i_out_ready;
    assign w_state    = skid_state_e'({w_main_valid, w_skid_valid});

    always_comb begin
        w_main_load     = 1'b0;
        w_main_clear    = 1'b0;
        w_main_sel_skid = 1'b0;
        w_skid_load     = 1'b0;
        w_skid_clear    = 1'b0;
        case (w_state)
            SKID_EMPTY: w_main_load = w_accept;
            SKID_ONE: begin
                if (w_accept && w_consume) begin
                    w_main_load = 1'b1;
                end else if (w_accept) begin
                    w_skid_load = 1'b1;
                end else if (w_consume) begin
                    w_main_clear = 1'b1;
                end
            end
            SKID_TWO: begin
                if (w_consume) begin
                    w_main_load     = 1'b1;
                    w_main_sel_skid = 1'b1;
                    w_skid_clear    = 1'b1;
                end
            end
            default: begin
                w_main_clear = 1'b1;
                w_skid_clear = 1'b1;
            end
        endcase
        if (i_flush) begin
            w_main_load  = 1'b0;
            w_skid_load  = 1'b0;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end
    end

    assign w_main_d = w_main_sel_skid ? w_skid_q : w_in_payload;

    mem_wb_skid_wb_slot #(.W(PW)) u_main (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d),
        .o_valid (w_main_valid),
        .o_data  (w_main_q)
    );

    mem_wb_skid_wb_slot #(.W(PW)) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_payload),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_q)
    );

    assign {w_h_rd_addr, w_h_wreg, w_h_wdata,
            w_h_csr_waddr, w_h_csr_wreg, w_h_csr_wdata} = w_main_q;

    // A write to x0 still retires but never reaches the regfile or the bypass network.
    assign w_gpr_we = w_main_valid & w_h_wreg & (w_h_rd_addr != '0);
    assign w_csr_we = w_main_valid & w_h_csr_wreg;

    assign o_out_valid     = w_main_valid;
    assign o_out_rd_addr   = w_h_rd_addr;
    assign o_out_wreg      = w_gpr_we;
    assign o_out_wdata     = w_h_wdata;
    assign o_out_csr_waddr = w_h_csr_waddr;
    assign o_out_csr_wreg  = w_csr_we;
    assign o_out_csr_wdata = w_h_csr_wdata;

    assign o_fwd_rd_addr   = w_h_rd_addr;
    assign o_fwd_wreg      = w_gpr_we;
    assign o_fwd_wdata     = w_h_wdata;
    assign o_fwd_csr_waddr = w_h_csr_waddr;
    assign o_fwd_csr_wreg  = w_csr_we;
    assign o_fwd_csr_wdata = w_h_csr_wdata;

    // A consume in a flush cycle still completed, so it is counted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_retire_cnt <= '0;
        end else if (w_consume) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign o_retire_cnt = r_retire_cnt;

endmodule
